// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out receiver.
// Bits on d, qualified by en, are assembled into WIDTH-bit words. Each
// finished word is offered on q with a valid/ready handshake. A word that
// completes while the previous one is still unconsumed is dropped, and the
// sticky overrun flag is set. Every output comes straight from a register.
module sipo_deserializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             d,
   input  logic             q_ready,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   output logic             overrun
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             vld_q, vld_d;
   logic             ovr_q, ovr_d;

   logic [WIDTH-1:0] shifted;
   logic             complete;
   logic             take;

   // Insert one new bit into the partial word, honouring the bit order.
   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                 input logic             bit_in);
      if (MSB_FIRST)
         return {cur[WIDTH-2:0], bit_in};
      else
         return {bit_in, cur[WIDTH-1:1]};
   endfunction

   // Next-state logic for the shifter, the bit counter and the output handshake.
   always_comb begin
      sr_d     = sr_q;
      cnt_d    = cnt_q;
      word_d   = word_q;
      vld_d    = vld_q;
      ovr_d    = ovr_q;
      shifted  = shift_in(sr_q, d);
      complete = en && (cnt_q == CNT_LAST);
      take     = vld_q && q_ready;

      if (en) begin
         if (complete) begin
            sr_d  = '0;
            cnt_d = '0;
         end else begin
            sr_d  = shifted;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      if (complete) begin
         if (!vld_q || take) begin
            // The slot is empty or is being emptied on this edge: load the new word.
            word_d = shifted;
            vld_d  = 1'b1;
         end else begin
            // The consumer is still holding the previous word, so the new one is lost.
            ovr_d = 1'b1;
         end
      end else if (take) begin
         vld_d = 1'b0;
      end
   end

   // State registers; reset discards any partial word and any pending output.
   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q   <= '0;
         cnt_q  <= '0;
         word_q <= '0;
         vld_q  <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         sr_q   <= sr_d;
         cnt_q  <= cnt_d;
         word_q <= word_d;
         vld_q  <= vld_d;
         ovr_q  <= ovr_d;
      end
   end

   assign q       = word_q;
   assign q_valid = vld_q;
   assign overrun = ovr_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer.
// Two instances, one MSB-first and one LSB-first, receive the same serial
// stream. Each is checked against words worked out by hand.
module tb_sipo_deserializer;

   logic       clk = 1'b0;
   logic       reset, en, d, q_ready;
   logic [7:0] q_m, q_l;
   logic       v_m, v_l, o_m, o_l;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .reset(reset), .en(en), .d(d), .q_ready(q_ready),
      .q(q_m), .q_valid(v_m), .overrun(o_m)
   );

   sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .en(en), .d(d), .q_ready(q_ready),
      .q(q_l), .q_valid(v_l), .overrun(o_l)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then sample 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      en = 1'b1;
      d  = b;
      step();
      en = 1'b0;
      d  = 1'b0;
   endtask

   // Send v[7] first, so v is the word as the MSB-first instance sees it.
   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   initial begin
      logic [7:0] pat;
      reset = 1'b1; en = 1'b0; d = 1'b0; q_ready = 1'b0;
      step();
      chk("rst_q", q_m, 8'h00);
      chk("rst_valid", v_m, 0);
      chk("rst_ovr", o_m, 0);
      chk("rst_valid_l", v_l, 0);
      reset = 1'b0;

      // Test 1: stream 0,0,0,1,1,1,1,0
      q_ready = 1'b1;
      send_byte(8'h1E);
      chk("t1_q_msb", q_m, 8'h1E);
      chk("t1_valid_msb", v_m, 1);
      chk("t1_ovr_msb", o_m, 0);
      // Test 2a: the same bits, LSB first
      chk("t2_q_lsb", q_l, 8'h78);
      chk("t2_valid_lsb", v_l, 1);
      step();
      chk("t1_valid_drop", v_m, 0);
      chk("t1_q_hold", q_m, 8'h1E);
      chk("t2_valid_drop_l", v_l, 0);

      // Test 2b: stream 0,1,1,1,1,0,0,0
      send_byte(8'h78);
      chk("t2b_q_lsb", q_l, 8'h1E);
      chk("t2b_q_msb", q_m, 8'h78);
      step();
      chk("t2b_valid_drop", v_l, 0);

      // Test 3: 0xA5 with en gaps after bit 3 (3 cycles) and bit 6 (1 cycle)
      pat = 8'hA5;
      for (int i = 7; i >= 5; i--) send_bit(pat[i]);
      step(); step(); step();
      chk("t3_gap1_valid", v_m, 0);
      for (int i = 4; i >= 2; i--) send_bit(pat[i]);
      step();
      send_bit(pat[1]);
      chk("t3_bit7_valid", v_m, 0);
      send_bit(pat[0]);
      chk("t3_q", q_m, 8'hA5);
      chk("t3_valid", v_m, 1);
      chk("t3_q_lsb", q_l, 8'hA5);
      step();
      chk("t3_consumed", v_m, 0);

      // Test 4: back-pressure, 0x3C then 0xFF while q_ready=0
      q_ready = 1'b0;
      send_byte(8'h3C);
      chk("t4_first_q", q_m, 8'h3C);
      chk("t4_first_ovr", o_m, 0);
      send_byte(8'hFF);
      chk("t4_q_hold", q_m, 8'h3C);
      chk("t4_valid_hold", v_m, 1);
      chk("t4_ovr", o_m, 1);
      chk("t4_ovr_lsb", o_l, 1);
      q_ready = 1'b1;
      step();
      q_ready = 1'b0;
      chk("t4_consume_valid", v_m, 0);
      chk("t4_ovr_sticky", o_m, 1);
      step();
      chk("t4_ovr_sticky2", o_m, 1);

      // Test 5: complete and consume on the same edge
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t5_rst_ovr", o_m, 0);
      send_byte(8'h3C);
      chk("t5_pre_q", q_m, 8'h3C);
      chk("t5_pre_valid", v_m, 1);
      pat = 8'hC3;
      for (int i = 7; i >= 1; i--) send_bit(pat[i]);
      chk("t5_bit7_q_hold", q_m, 8'h3C);
      q_ready = 1'b1;
      send_bit(pat[0]);
      q_ready = 1'b0;
      chk("t5_q", q_m, 8'hC3);
      chk("t5_valid", v_m, 1);
      chk("t5_ovr", o_m, 0);
      chk("t5_q_lsb", q_l, 8'hC3);

      // Test 6: reset mid-word while the word 0xC3 is still pending
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      reset = 1'b1; en = 1'b1; d = 1'b1; q_ready = 1'b1;
      step();
      chk("t6_rst_valid", v_m, 0);
      chk("t6_rst_ovr", o_m, 0);
      chk("t6_rst_q", q_m, 8'h00);
      reset = 1'b0; en = 1'b0; d = 1'b0;
      pat = 8'h81;
      for (int i = 7; i >= 5; i--) send_bit(pat[i]);
      chk("t6_no_stale_valid", v_m, 0);
      for (int i = 4; i >= 1; i--) send_bit(pat[i]);
      chk("t6_bit7_valid", v_m, 0);
      send_bit(pat[0]);
      chk("t6_q", q_m, 8'h81);
      chk("t6_valid", v_m, 1);
      chk("t6_q_lsb", q_l, 8'h81);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
